mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// Shares the single-port instruction/data SRAM between the fetch requester and the
// load/store requester with a one-access-per-cycle grant scheme. Issues exactly one
// SRAM access per cycle, tracks in-flight reads through a tag pipeline matching the
// SRAM read latency, and routes each read word back to the requester that issued it.
// Data side has priority; a starvation counter guarantees fetch forward progress.
// PARAMETERS
// ADDR_W      12  SRAM word-address width; low ADDR_W bits of requester word address used
// READ_LAT    1   SRAM read latency in clk cycles, address issue to q valid (1..4)
// STARVE_MAX  3   consecutive denied fetch cycles before fetch overrides data priority (1..15)
// PORTS
// clk          in   1       system clock, all state on posedge
// rst          in   1       asynchronous, active-high reset
// if_req       in   1       fetch read request, held until granted
// if_addr      in   30      fetch word address (byte PC[31:2])
// if_gnt       out  1       fetch accepted this cycle (combinational)
// if_valid     out  1       one-cycle pulse: if_rdata holds the granted fetch word
// if_rdata     out  32      fetched instruction, held until next if_valid
// d_req        in   1       data request, held until granted
// d_we         in   1       1 = store, 0 = load
// d_addr       in   30      data word address
// d_wdata      in   32      store data
// d_gnt        out  1       data request accepted this cycle (combinational)
// d_valid      out  1       one-cycle pulse: d_rdata holds granted load word
// d_rdata      out  32      load data, held until next d_valid
// sram_address out  ADDR_W  SRAM word address (combinational from winner)
// sram_data    out  32      SRAM write data (d_wdata pass-through)
// sram_wren    out  1       SRAM write enable; forced 0 while rst
// sram_q       in   32      SRAM read data, valid READ_LAT cycles after address
// starved      out  1       fetch override active this cycle (debug/perf)
// BEHAVIOUR
// - Grant (combinational, every cycle): if if_req && starve_cnt==STARVE_MAX -> fetch;
//   else if d_req -> data; else if if_req -> fetch; else none. At most one gnt high.
// - Access is taken at posedge when req && gnt. Requester must hold req/addr/we/wdata
//   stable until gnt; deasserting req before gnt is allowed (request withdrawn).
// - sram_address = winner addr[ADDR_W-1:0]; 0 when no winner. sram_wren = d_gnt && d_we && !rst.
// - starve_cnt (4 bit): cleared on if_gnt or !if_req; +1 when if_req && !if_gnt;
//   saturates at STARVE_MAX. starved = if_req && starve_cnt==STARVE_MAX.
// - Tag pipeline: READ_LAT stages of {valid, src}; stage0 loaded each cycle with
//   {if_gnt | (d_gnt & !d_we), if_gnt ? FETCH : DATA}; shifts every cycle, no stall.
// - When last stage valid: capture sram_q into if_rdata or d_rdata per src, pulse the
//   matching *_valid for exactly one cycle. Latency: gnt cycle N -> *_valid in cycle N+READ_LAT.
// - Stores: complete in grant cycle; no d_valid pulse; d_rdata unchanged.
// - Responses return strictly in grant order; back-to-back reads from either side
//   sustain one response per cycle.
// - Simultaneous if_req and d_req with STARVE_MAX reached: fetch wins, data waits >=1 cycle.
// - Reset (async, any time): tag pipeline valids 0, starve_cnt 0, if_rdata/d_rdata 0,
//   if_valid/d_valid 0; in-flight reads discarded, never reported after reset release.
//   Grants/sram outputs depend only on inputs, but sram_wren is 0 throughout rst.
// - Address bits above ADDR_W ignored (aliasing by design, no error).
// TESTING
// - Reset: rst=1 with d_req=1,d_we=1 -> sram_wren=0, all valids 0, rdata 0; release -> d_gnt=1.
// - Lone fetch: if_req, if_addr=0x10, sram q=0x8C010004 at addr 0x10, READ_LAT=1 ->
//   if_gnt in N, if_valid with if_rdata=0x8C010004 in N+1.
// - Conflict: if_req and d_req (load 0x20) held -> d_gnt first; fetch granted after at most
//   STARVE_MAX(=3) denials; starved=1 exactly in override cycle.
// - Store: d_we=1,d_addr=0x5,d_wdata=0xDEADBEEF -> sram_wren=1, sram_address=0x5 one cycle;
//   later load of 0x5 returns d_rdata=0xDEADBEEF; no d_valid for the store.
// - Interleave, READ_LAT=3: grants F,D,F,D on consecutive cycles -> valids in same order 3
//   cycles later, each word routed to correct side.
// - Mid-flight reset: fetch granted, rst pulsed before N+READ_LAT -> no if_valid afterwards.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and SRAM-side signals for the memory port arbiter.
// The arbiter takes the slave view; the requesters/SRAM environment take the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic              if_req;
  logic [29:0]       if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [31:0]       if_rdata;

  logic              d_req;
  logic              d_we;
  logic [29:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_valid;
  logic [31:0]       d_rdata;

  logic [ADDR_W-1:0] sram_address;
  logic [31:0]       sram_data;
  logic              sram_wren;
  logic [31:0]       sram_q;

  logic              starved;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, sram_q,
    output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           sram_address, sram_data, sram_wren, starved
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, sram_q,
    input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           sram_address, sram_data, sram_wren, starved
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// One-access-per-cycle arbiter sharing a single-port SRAM between fetch and load/store,
// with a read-tag pipeline that routes each returning word to the requester that issued it.
module mem_port_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int READ_LAT   = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic                starve_cnt_hit;
  logic [3:0]          starve_cnt;
  logic                fetch_win;
  logic                data_win;
  logic                issue_vld;
  logic [ADDR_W-1:0]   sram_address;

  logic [READ_LAT-1:0] vld_p;
  logic [READ_LAT-1:0] src_p;
  logic                rsp_if;
  logic                rsp_d;
  logic [31:0]         if_rdata_q;
  logic [31:0]         d_rdata_q;

  // Grant: fetch override once starved, otherwise data has priority
  always_comb begin
    starve_cnt_hit = bus.if_req && (starve_cnt == STARVE_LIM);
    fetch_win      = starve_cnt_hit || (bus.if_req && !bus.d_req);
    data_win       = bus.d_req && !fetch_win;
    issue_vld      = fetch_win || (data_win && !bus.d_we);
  end

  always_comb begin
    sram_address = '0;
    if (fetch_win)
      sram_address = bus.if_addr[ADDR_W-1:0];
    else if (data_win)
      sram_address = bus.d_addr[ADDR_W-1:0];
  end

  assign bus.if_gnt       = fetch_win;
  assign bus.d_gnt        = data_win;
  assign bus.starved      = starve_cnt_hit;
  assign bus.sram_address = sram_address;
  assign bus.sram_data    = bus.d_wdata;
  assign bus.sram_wren    = data_win && bus.d_we && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      starve_cnt <= 4'd0;
    else if (!bus.if_req || fetch_win)
      starve_cnt <= 4'd0;
    else if (starve_cnt != STARVE_LIM)
      starve_cnt <= starve_cnt + 4'd1;
  end

  // Tag stages p0..p(READ_LAT-1): one per cycle of SRAM read latency, never stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= issue_vld;
      for (int i = 1; i < READ_LAT; i++)
        vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    src_p[0] <= fetch_win;
    for (int i = 1; i < READ_LAT; i++)
      src_p[i] <= src_p[i-1];
  end

  // Response stage: the word is presented straight from sram_q and held afterwards
  assign rsp_if = vld_p[READ_LAT-1] && src_p[READ_LAT-1];
  assign rsp_d  = vld_p[READ_LAT-1] && !src_p[READ_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rdata_q <= 32'd0;
      d_rdata_q  <= 32'd0;
    end else begin
      if (rsp_if)
        if_rdata_q <= bus.sram_q;
      if (rsp_d)
        d_rdata_q <= bus.sram_q;
    end
  end

  assign bus.if_valid = rsp_if;
  assign bus.d_valid  = rsp_d;
  assign bus.if_rdata = rsp_if ? bus.sram_q : if_rdata_q;
  assign bus.d_rdata  = rsp_d ? bus.sram_q : d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (read latency 1 and 3) share one stimulus stream
// and are compared each cycle against a transaction-level model of the arbiter and SRAM.
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 12;
  localparam int STARVE_MAX = 3;
  localparam int DEPTH      = 1 << ADDR_W;

  typedef struct {
    int          cyc;
    bit          fetch;
    logic [31:0] data;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [29:0] if_addr, d_addr;
  logic [31:0] d_wdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus1 ();
  mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus3 ();

  assign bus1.if_req  = if_req;
  assign bus1.if_addr = if_addr;
  assign bus1.d_req   = d_req;
  assign bus1.d_we    = d_we;
  assign bus1.d_addr  = d_addr;
  assign bus1.d_wdata = d_wdata;
  assign bus3.if_req  = if_req;
  assign bus3.if_addr = if_addr;
  assign bus3.d_req   = d_req;
  assign bus3.d_we    = d_we;
  assign bus3.d_addr  = d_addr;
  assign bus3.d_wdata = d_wdata;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .READ_LAT(1), .STARVE_MAX(STARVE_MAX)) u_lat1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );
  mem_port_arbiter #(.ADDR_W(ADDR_W), .READ_LAT(3), .STARVE_MAX(STARVE_MAX)) u_lat3 (
    .clk(clk), .rst(rst), .bus(bus3.slave)
  );

  // SRAM environment for each instance: synchronous read, output delayed to its latency
  logic [31:0] mem1 [DEPTH];
  logic [31:0] mem3 [DEPTH];
  logic [31:0] rd1;
  logic [31:0] rd3 [3];

  always @(posedge clk) begin
    if (bus1.sram_wren) mem1[bus1.sram_address] <= bus1.sram_data;
    rd1 <= mem1[bus1.sram_address];
  end
  always @(posedge clk) begin
    if (bus3.sram_wren) mem3[bus3.sram_address] <= bus3.sram_data;
    rd3[0] <= mem3[bus3.sram_address];
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end
  assign bus1.sram_q = rd1;
  assign bus3.sram_q = rd3[2];

  // Reference model state
  logic [31:0]       ref_mem [DEPTH];
  rec_t              q1[$];
  rec_t              q3[$];
  logic [31:0]       eif1, ed1, eif3, ed3;
  int                denied;
  logic              e_st, e_ifg, e_dg, e_wren;
  logic [ADDR_W-1:0] e_addr;
  logic              g_if, g_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_ctl(input string pfx, input logic ifg, input logic dg, input logic st,
                         input logic [ADDR_W-1:0] addr, input logic wren, input logic [31:0] wd);
    chk({pfx, "_if_gnt"}, 32'(ifg), 32'(e_ifg));
    chk({pfx, "_d_gnt"}, 32'(dg), 32'(e_dg));
    chk({pfx, "_starved"}, 32'(st), 32'(e_st));
    chk({pfx, "_sram_addr"}, 32'(addr), 32'(e_addr));
    chk({pfx, "_sram_wren"}, 32'(wren), 32'(e_wren));
    chk({pfx, "_sram_data"}, wd, d_wdata);
  endtask

  task automatic chk_rsp(input string pfx, input bit has, input rec_t h,
                         input logic ifv, input logic dv, input logic [31:0] ifr,
                         input logic [31:0] dr, inout logic [31:0] exp_ifr,
                         inout logic [31:0] exp_dr);
    if (has && h.fetch) exp_ifr = h.data;
    if (has && !h.fetch) exp_dr = h.data;
    chk({pfx, "_if_valid"}, 32'(ifv), 32'(has && h.fetch));
    chk({pfx, "_d_valid"}, 32'(dv), 32'(has && !h.fetch));
    chk({pfx, "_if_rdata"}, ifr, exp_ifr);
    chk({pfx, "_d_rdata"}, dr, exp_dr);
  endtask

  // One clock cycle: check at the falling edge, advance the model, return just after posedge
  task automatic tick();
    bit          p1, p3;
    rec_t        h1, h3;
    logic [31:0] r;
    @(negedge clk);
    cyc++;
    if (rst) begin
      q1.delete(); q3.delete();
      eif1 = 0; ed1 = 0; eif3 = 0; ed3 = 0;
      denied = 0;
    end
    e_st   = if_req && (denied == STARVE_MAX);
    e_ifg  = if_req && (e_st || !d_req);
    e_dg   = d_req && !e_ifg;
    e_addr = e_ifg ? if_addr[ADDR_W-1:0] : (e_dg ? d_addr[ADDR_W-1:0] : '0);
    e_wren = e_dg && d_we && !rst;
    chk_ctl("l1", bus1.if_gnt, bus1.d_gnt, bus1.starved, bus1.sram_address, bus1.sram_wren, bus1.sram_data);
    chk_ctl("l3", bus3.if_gnt, bus3.d_gnt, bus3.starved, bus3.sram_address, bus3.sram_wren, bus3.sram_data);

    while (q1.size() > 0 && q1[0].cyc < cyc) void'(q1.pop_front());
    while (q3.size() > 0 && q3[0].cyc < cyc) void'(q3.pop_front());
    p1 = (q1.size() > 0) && (q1[0].cyc == cyc);
    p3 = (q3.size() > 0) && (q3[0].cyc == cyc);
    h1 = '{0, 1'b0, 32'h0};
    h3 = '{0, 1'b0, 32'h0};
    if (p1) h1 = q1.pop_front();
    if (p3) h3 = q3.pop_front();
    chk_rsp("l1", p1, h1, bus1.if_valid, bus1.d_valid, bus1.if_rdata, bus1.d_rdata, eif1, ed1);
    chk_rsp("l3", p3, h3, bus3.if_valid, bus3.d_valid, bus3.if_rdata, bus3.d_rdata, eif3, ed3);

    if (!rst) begin
      if (e_ifg) begin
        r = ref_mem[if_addr[ADDR_W-1:0]];
        q1.push_back('{cyc + 1, 1'b1, r});
        q3.push_back('{cyc + 3, 1'b1, r});
      end else if (e_dg && !d_we) begin
        r = ref_mem[d_addr[ADDR_W-1:0]];
        q1.push_back('{cyc + 1, 1'b0, r});
        q3.push_back('{cyc + 3, 1'b0, r});
      end else if (e_wren) begin
        ref_mem[d_addr[ADDR_W-1:0]] = d_wdata;
      end
      if (!if_req || e_ifg) denied = 0;
      else if (denied < STARVE_MAX) denied++;
    end
    g_if = e_ifg;
    g_d  = e_dg;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] v;
    int          waits;

    rst = 1'b1;
    if_req = 0; if_addr = '0;
    d_req = 1; d_we = 1; d_addr = 30'h5; d_wdata = 32'h0000_1234;
    denied = 0; g_if = 0; g_d = 0;
    eif1 = 0; ed1 = 0; eif3 = 0; ed3 = 0;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      if (i == 'h10) v = 32'h8C01_0004;
      ref_mem[i] = v;
      mem1[i] <= v;
      mem3[i] <= v;
    end
    @(posedge clk);
    #1;

    // Reset held with a pending store: no write, no responses, grants still follow inputs
    repeat (3) tick();
    chk("rst_l1_dgnt_comb", 32'(bus1.d_gnt), 32'd1);
    rst = 1'b0;
    tick();
    d_req = 0;
    tick();

    // Lone fetch of 0x10
    if_req = 1; if_addr = 30'h10;
    tick();
    if_req = 0;
    repeat (4) tick();
    chk("lone_l1_if_rdata", bus1.if_rdata, 32'h8C01_0004);
    chk("lone_l3_if_rdata", bus3.if_rdata, 32'h8C01_0004);

    // Conflict: fetch held against a continuous stream of loads
    if_req = 1; if_addr = 30'h11;
    d_req = 1; d_we = 0; d_addr = 30'h20;
    waits = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (g_if) break;
      waits++;
    end
    chk("conflict_denials", 32'(waits), 32'(STARVE_MAX));
    if_req = 0; d_req = 0;
    repeat (4) tick();

    // Store 0x5 then load it back
    d_req = 1; d_we = 1; d_addr = 30'h5; d_wdata = 32'hDEAD_BEEF;
    tick();
    d_we = 0;
    tick();
    d_req = 0;
    repeat (4) tick();
    chk("store_l1_d_rdata", bus1.d_rdata, 32'hDEAD_BEEF);
    chk("store_l3_d_rdata", bus3.d_rdata, 32'hDEAD_BEEF);

    // Interleave F,D,F,D on consecutive cycles
    for (int i = 0; i < 4; i++) begin
      if_req = (i % 2 == 0); if_addr = 30'(32'h30 + i);
      d_req  = (i % 2 == 1); d_we = 0; d_addr = 30'(32'h30 + i);
      tick();
    end
    if_req = 0; d_req = 0;
    repeat (5) tick();

    // Reset while a fetch is in flight
    if_req = 1; if_addr = 30'h40;
    tick();
    if_req = 0;
    rst = 1;
    repeat (2) tick();
    rst = 0;
    repeat (6) tick();

    // Randomized traffic with occasional withdrawals, aliasing addresses and reset pulses
    for (int n = 0; n < 3000; n++) begin
      if (!if_req || g_if) begin
        if_req = ($urandom % 100) < 60;
        v = $urandom;
        if_addr = v[29:0];
        if ($urandom % 2) if_addr[11:4] = '0;
      end else if ($urandom % 20 == 0) begin
        if_req = 0;
      end
      if (!d_req || g_d) begin
        d_req = ($urandom % 100) < 70;
        d_we = $urandom % 2;
        v = $urandom;
        d_addr = v[29:0];
        if ($urandom % 2) d_addr[11:4] = '0;
        d_wdata = $urandom;
      end else if ($urandom % 20 == 0) begin
        d_req = 0;
      end
      if ($urandom % 500 == 0) begin
        rst = 1;
        repeat (2) tick();
        rst = 0;
      end
      tick();
    end
    if_req = 0; d_req = 0;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
